// File: rtl/if_stage_if.sv
// Fetch-stage bus: IMEM fetch port, pipeline control inputs and IF/ID register outputs.
interface if_stage_if;
  logic [31:0] imem_pc;
  logic [31:0] imem_instr;
  logic        stall;
  logic        flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_pc_plus4;
  logic [31:0] id_instr;
  logic        fetch_fault;
  logic [31:0] fetch_count;

  // The fetch stage itself.
  modport master (
    output imem_pc, id_valid, id_pc, id_pc_plus4, id_instr, fetch_fault, fetch_count,
    input  imem_instr, stall, flush, redirect_valid, redirect_pc
  );

  // IMEM plus the later pipeline stages that steer fetch.
  modport slave (
    input  imem_pc, id_valid, id_pc, id_pc_plus4, id_instr, fetch_fault, fetch_count,
    output imem_instr, stall, flush, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, IMEM address drive and IF/ID pipeline register.
// Redirect beats flush beats stall; an illegal fetch address halts the stage until reset.
module if_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          IMEM_SIZE = 1024
) (
  input  logic       clk,
  input  logic       rst_n,
  if_stage_if.master bus
);

  // Highest word-aligned address whose four bytes all lie inside IMEM.
  localparam logic [31:0] LAST_PC = 32'(IMEM_SIZE - 4);

  typedef enum logic [1:0] {
    ST_BOOT,
    ST_RUN,
    ST_HALT
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        id_valid_q, id_valid_d;
  logic [31:0] id_pc_q, id_pc_d;
  logic [31:0] id_pc_plus4_q, id_pc_plus4_d;
  logic [31:0] id_instr_q, id_instr_d;
  logic        fetch_fault_q, fetch_fault_d;
  logic [31:0] fetch_count_q, fetch_count_d;

  logic [31:0] pc_plus4;
  logic        pc_legal;

  assign pc_plus4 = pc_q + 32'd4;
  assign pc_legal = (pc_q[1:0] == 2'b00) && (pc_q <= LAST_PC);

  // Next-state and next-register logic; every register holds unless a rule below fires.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    id_valid_d    = id_valid_q;
    id_pc_d       = id_pc_q;
    id_pc_plus4_d = id_pc_plus4_q;
    id_instr_d    = id_instr_q;
    fetch_fault_d = fetch_fault_q;
    fetch_count_d = fetch_count_q;

    unique case (state_q)
      ST_BOOT: begin
        // One settling cycle after reset; nothing is captured.
        state_d = ST_RUN;
      end

      ST_RUN: begin
        if (bus.redirect_valid) begin
          // Target is taken as-is; legality is judged when it is fetched.
          pc_d       = bus.redirect_pc;
          id_valid_d = 1'b0;
        end else if (bus.flush) begin
          if (!bus.stall) begin
            pc_d = pc_plus4;
          end
          id_valid_d = 1'b0;
        end else if (bus.stall) begin
          // Hold everything.
        end else if (pc_legal) begin
          id_valid_d    = 1'b1;
          id_pc_d       = pc_q;
          id_pc_plus4_d = pc_plus4;
          id_instr_d    = bus.imem_instr;
          pc_d          = pc_plus4;
          fetch_count_d = fetch_count_q + 32'd1;
        end else begin
          id_valid_d    = 1'b0;
          fetch_fault_d = 1'b1;
          state_d       = ST_HALT;
        end
      end

      ST_HALT: begin
        // Terminal: PC frozen, IF/ID empty, fault stays asserted.
        id_valid_d    = 1'b0;
        fetch_fault_d = 1'b1;
      end

      default: begin
        state_d = ST_HALT;
      end
    endcase
  end

  // State and datapath registers; reset takes effect immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_BOOT;
      pc_q          <= RESET_PC;
      id_valid_q    <= 1'b0;
      id_pc_q       <= 32'd0;
      id_pc_plus4_q <= 32'd0;
      id_instr_q    <= 32'd0;
      fetch_fault_q <= 1'b0;
      fetch_count_q <= 32'd0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      id_valid_q    <= id_valid_d;
      id_pc_q       <= id_pc_d;
      id_pc_plus4_q <= id_pc_plus4_d;
      id_instr_q    <= id_instr_d;
      fetch_fault_q <= fetch_fault_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  assign bus.imem_pc     = pc_q;
  assign bus.id_valid    = id_valid_q;
  assign bus.id_pc       = id_pc_q;
  assign bus.id_pc_plus4 = id_pc_plus4_q;
  assign bus.id_instr    = id_instr_q;
  assign bus.fetch_fault = fetch_fault_q;
  assign bus.fetch_count = fetch_count_q;

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed scenarios plus random stall/flush/redirect traffic,
// checked by a scoreboard fed from a behavioural model of the fetch rules.
module tb_if_stage;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  if_stage_if bus();

  if_stage #(.RESET_PC(32'h0000_0000), .IMEM_SIZE(1024)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Combinational IMEM: 256 words, byte addressed.
  logic [31:0] mem [0:255];
  assign bus.imem_instr = (bus.imem_pc < 32'd1024) ? mem[bus.imem_pc[9:2]] : 32'hDEAD_BEEF;

  typedef struct {
    int          due;
    logic [31:0] pc;
    logic        valid;
    logic [31:0] idpc;
    logic [31:0] idpc4;
    logic [31:0] instr;
    logic        fault;
    logic [31:0] count;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;

  // Reference model state.
  bit          m_booted;
  bit          m_halted;
  logic [31:0] m_pc;
  logic        m_valid;
  logic [31:0] m_idpc, m_idpc4, m_instr, m_count;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, want);
    end
  endtask

  function automatic bit legal(input logic [31:0] a);
    return (a % 4 == 0) && (a < 1024);
  endfunction

  task automatic model_reset();
    m_booted = 0; m_halted = 0; m_pc = 32'h0; m_valid = 0;
    m_idpc = 0; m_idpc4 = 0; m_instr = 0; m_count = 0;
  endtask

  // One cycle of stimulus: drive inputs, advance the model, queue the expectation.
  task automatic step(input bit st, input bit fl, input bit rv, input logic [31:0] rpc);
    exp_t e;
    bus.stall = st; bus.flush = fl; bus.redirect_valid = rv; bus.redirect_pc = rpc;
    if (!m_booted) begin
      m_booted = 1;
    end else if (m_halted) begin
      m_valid = 0;
    end else if (rv) begin
      m_pc = rpc; m_valid = 0;
    end else if (fl) begin
      if (!st) m_pc = m_pc + 4;
      m_valid = 0;
    end else if (st) begin
      // nothing moves
    end else if (legal(m_pc)) begin
      m_valid = 1; m_idpc = m_pc; m_idpc4 = m_pc + 4; m_instr = mem[m_pc[9:2]];
      m_pc = m_pc + 4; m_count = m_count + 1;
    end else begin
      m_valid = 0; m_halted = 1;
    end
    e.due = cyc + 1; e.pc = m_pc; e.valid = m_valid; e.idpc = m_idpc; e.idpc4 = m_idpc4;
    e.instr = m_instr; e.fault = m_halted; e.count = m_count;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 32'h0);
  endtask

  task automatic check_reset_values();
    chk("rst_imem_pc", bus.imem_pc, 32'h0);
    chk("rst_id_valid", {31'd0, bus.id_valid}, 32'd0);
    chk("rst_id_pc", bus.id_pc, 32'h0);
    chk("rst_id_pc_plus4", bus.id_pc_plus4, 32'h0);
    chk("rst_id_instr", bus.id_instr, 32'h0);
    chk("rst_fetch_fault", {31'd0, bus.fetch_fault}, 32'd0);
    chk("rst_fetch_count", bus.fetch_count, 32'h0);
  endtask

  // Asynchronous reset asserted between clock edges; outputs must clear at once.
  task automatic do_reset();
    #6;
    rst_n = 0;
    #1;
    check_reset_values();
    q.delete();
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1;
  endtask

  // Monitor: compare every expectation that has come due against the DUT outputs.
  always @(negedge clk) begin
    while (rst_n && q.size() > 0 && q[0].due <= cyc) begin
      exp_t e;
      e = q.pop_front();
      chk("imem_pc", bus.imem_pc, e.pc);
      chk("id_valid", {31'd0, bus.id_valid}, {31'd0, e.valid});
      chk("fetch_fault", {31'd0, bus.fetch_fault}, {31'd0, e.fault});
      chk("fetch_count", bus.fetch_count, e.count);
      if (e.valid) begin
        chk("id_pc", bus.id_pc, e.idpc);
        chk("id_pc_plus4", bus.id_pc_plus4, e.idpc4);
        chk("id_instr", bus.id_instr, e.instr);
      end
      $display("cycle %0d: pc=%h v=%0b id_pc=%h instr=%h fault=%0b cnt=%0d",
               cyc, bus.imem_pc, bus.id_valid, bus.id_pc, bus.id_instr, bus.fetch_fault, bus.fetch_count);
    end
  end

  initial begin
    logic [31:0] tgt;
    int r;
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    mem[0] = 32'h0000_0000;
    mem[1] = 32'h0040_0093;
    mem[2] = 32'h0010_0113;
    mem[11] = 32'h0000_15B7;
    bus.stall = 0; bus.flush = 0; bus.redirect_valid = 0; bus.redirect_pc = 0;
    model_reset();

    // Power-on reset.
    rst_n = 0;
    #3;
    check_reset_values();
    @(posedge clk);
    #1;
    rst_n = 1;

    // Boot cycle then sequential fetch of 0, 4, 8.
    idle(4);
    // Stall two cycles with id_pc=8, then resume.
    step(1, 0, 0, 0); step(1, 0, 0, 0); idle(1);
    // Redirect with simultaneous stall, then fetch the target.
    step(1, 0, 1, 32'h2C); idle(1);
    // Flush together with stall at pc=0x10.
    step(0, 0, 1, 32'h10); step(1, 1, 0, 0); step(0, 1, 0, 0); idle(2);
    // Misaligned redirect halts; further redirects ignored.
    step(0, 0, 1, 32'h2E); idle(1);
    for (int i = 0; i < 10; i++) step(0, 0, 1, 32'h40);
    // Last legal word then the first out-of-range address.
    do_reset();
    idle(1); step(0, 0, 1, 32'h3FC); idle(4);

    // Random traffic in several reset-separated segments.
    for (int s = 0; s < 8; s++) begin
      do_reset();
      for (int i = 0; i < 300; i++) begin
        r = $urandom_range(0, 99);
        if (r < 3) tgt = 32'h400;
        else if (r < 6) tgt = (32'($urandom_range(0, 255)) << 2) | 32'($urandom_range(1, 3));
        else tgt = 32'($urandom_range(0, 255)) << 2;
        step($urandom_range(0, 99) < 20, $urandom_range(0, 99) < 8,
             $urandom_range(0, 99) < 8, tgt);
      end
    end

    #10;
    chk("scoreboard_drained", 32'(q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
